// File: rtl/rf_wb_pkg.sv
// Shared types for the register-file write-side arbiter.
package rf_wb_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  // One register-file write: destination and data.
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

  // Source that owns the RF write port in a given cycle.
  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_WB,
    SRC_MDU
  } src_t;

  // One-hot register mask; x0 never appears in the mask.
  function automatic logic [XLEN-1:0] rd_onehot(input logic [REG_AW-1:0] rd);
    logic [XLEN-1:0] m;
    m = '0;
    if (rd != '0) m[rd] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Bus bundle for the RF write-side arbiter: pipeline WB, MDU result,
// MDU issue (scoreboard set) and the registered RF write port.
interface rf_wb_arbiter_if;

  logic                                wb_valid;
  logic [rf_wb_pkg::REG_AW-1:0]        wb_rd;
  logic [rf_wb_pkg::XLEN-1:0]          wb_data;

  logic                                mdu_valid;
  logic                                mdu_ready;
  logic [rf_wb_pkg::REG_AW-1:0]        mdu_rd;
  logic [rf_wb_pkg::XLEN-1:0]          mdu_data;

  logic                                iss_valid;
  logic [rf_wb_pkg::REG_AW-1:0]        iss_rd;

  logic                                wb_stall;
  logic [rf_wb_pkg::XLEN-1:0]          pend_mask;

  logic                                rf_wr;
  logic [rf_wb_pkg::REG_AW-1:0]        rf_a3;
  logic [rf_wb_pkg::XLEN-1:0]          rf_wd;

  // Pipeline / MDU / decode side.
  modport master (
    output wb_valid, wb_rd, wb_data,
    output mdu_valid, mdu_rd, mdu_data,
    output iss_valid, iss_rd,
    input  mdu_ready, wb_stall, pend_mask,
    input  rf_wr, rf_a3, rf_wd
  );

  // Arbiter side.
  modport slave (
    input  wb_valid, wb_rd, wb_data,
    input  mdu_valid, mdu_rd, mdu_data,
    input  iss_valid, iss_rd,
    output mdu_ready, wb_stall, pend_mask,
    output rf_wr, rf_a3, rf_wd
  );

endinterface

// File: rtl/rf_wb_fifo.sv
// Small synchronous FIFO of RF write requests buffering MDU results.
// Pointers carry one extra wrap bit so full/empty need no counter.
module rf_wb_fifo
  import rf_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  wb_req_t push_data,
  input  logic    pop,
  output wb_req_t head,
  output logic    full,
  output logic    empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  wb_req_t     mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  // Pointer update; reset flushes all buffered entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents are don't-care until the pointers cover them.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-side arbiter: merges the in-order WB stream with
// buffered MDU results onto a single registered RF write port, forces a
// pipeline stall when an MDU result starves, and tracks outstanding MDU
// destinations for the decode interlock.
// Optional: define WB_TRACE_EN for a simulation-only log of RF writes.
module rf_wb_arbiter
  import rf_wb_pkg::*;
#(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  rf_wb_arbiter_if.slave   bus
);

  localparam int unsigned CW = $clog2(STARVE_MAX + 1);

  wb_req_t           head;
  wb_req_t           push_data;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              issue;
  logic              blocked;
  src_t              sel;
  logic [REG_AW-1:0] a3_nxt;
  logic [XLEN-1:0]   wd_nxt;

  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     cnt_nxt;
  logic              stall_q;
  logic              stall_nxt;

  logic [XLEN-1:0]   pend_q;
  logic [XLEN-1:0]   pend_nxt;
  logic [XLEN-1:0]   pend_set;
  logic [XLEN-1:0]   pend_clr;

  logic              rf_wr_q;
  logic [REG_AW-1:0] rf_a3_q;
  logic [XLEN-1:0]   rf_wd_q;

  // mdu_ready depends on registered FIFO state only, so a full FIFO
  // refuses a push even in a cycle where it also pops.
  assign push      = bus.mdu_valid && !full;
  assign push_data = '{rd: bus.mdu_rd, data: bus.mdu_data};

  rf_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  // Port arbitration: pipeline first, then FIFO head; rd==0 is consumed
  // without asserting the write enable.
  always_comb begin
    sel    = SRC_NONE;
    pop    = 1'b0;
    issue  = 1'b0;
    a3_nxt = '0;
    wd_nxt = '0;
    if (bus.wb_valid && bus.wb_rd != '0) begin
      sel    = SRC_WB;
      issue  = 1'b1;
      a3_nxt = bus.wb_rd;
      wd_nxt = bus.wb_data;
    end else if (!empty) begin
      pop = 1'b1;
      if (head.rd != '0) begin
        sel    = SRC_MDU;
        issue  = 1'b1;
        a3_nxt = head.rd;
        wd_nxt = head.data;
      end
    end
  end

  // Starvation tracking: count cycles the head loses to the pipeline and
  // request a stall once the limit is reached or the FIFO is full.
  always_comb begin
    blocked = !empty && (sel == SRC_WB);
    cnt_nxt = cnt_q;
    if (empty || pop) begin
      cnt_nxt = '0;
    end else if (blocked && cnt_q != CW'(STARVE_MAX)) begin
      cnt_nxt = cnt_q + CW'(1);
    end
    stall_nxt = blocked && ((cnt_nxt >= CW'(STARVE_MAX - 1)) || full);
  end

  // Scoreboard: set on MDU issue, clear on MDU retire; set wins on a tie.
  always_comb begin
    pend_set    = bus.iss_valid ? rd_onehot(bus.iss_rd) : '0;
    pend_clr    = (sel == SRC_MDU) ? rd_onehot(head.rd) : '0;
    pend_nxt    = (pend_q & ~pend_clr) | pend_set;
    pend_nxt[0] = 1'b0;
  end

  // Control state: starve counter, stall request and scoreboard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      stall_q <= 1'b0;
      pend_q  <= '0;
    end else begin
      cnt_q   <= cnt_nxt;
      stall_q <= stall_nxt;
      pend_q  <= pend_nxt;
    end
  end

  // Registered RF write port; address/data hold when no write issues.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_wr_q <= 1'b0;
      rf_a3_q <= '0;
      rf_wd_q <= '0;
    end else begin
      rf_wr_q <= issue;
      if (issue) begin
        rf_a3_q <= a3_nxt;
        rf_wd_q <= wd_nxt;
      end
    end
  end

  assign bus.mdu_ready = !full;
  assign bus.wb_stall  = stall_q;
  assign bus.pend_mask = pend_q;
  assign bus.rf_wr     = rf_wr_q;
  assign bus.rf_a3     = rf_a3_q;
  assign bus.rf_wd     = rf_wd_q;

`ifdef WB_TRACE_EN
  src_t trace_src;

  // Remember who owns the write currently on the port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) trace_src <= SRC_NONE;
    else        trace_src <= sel;
  end

  // Log each write at the point the RF samples it.
  always @(negedge clk) begin
    if (rst_n && rf_wr_q)
      $display("%s x%0d = %h", (trace_src == SRC_WB) ? "WB" : "MDU",
               rf_a3_q, rf_wd_q);
  end
`else
  // No trace logic in the default build.
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter (DEPTH=2, STARVE_MAX=4).
module tb_rf_wb_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  rf_wb_arbiter_if bus();

  rf_wb_arbiter #(
    .DEPTH      (2),
    .STARVE_MAX (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wb_valid  = 1'b0;
    bus.wb_rd     = '0;
    bus.wb_data   = '0;
    bus.mdu_valid = 1'b0;
    bus.mdu_rd    = '0;
    bus.mdu_data  = '0;
    bus.iss_valid = 1'b0;
    bus.iss_rd    = '0;
  endtask

  task automatic wb(input logic [4:0] rd, input logic [31:0] d);
    bus.wb_valid = 1'b1;
    bus.wb_rd    = rd;
    bus.wb_data  = d;
  endtask

  task automatic mdu(input logic [4:0] rd, input logic [31:0] d);
    bus.mdu_valid = 1'b1;
    bus.mdu_rd    = rd;
    bus.mdu_data  = d;
  endtask

  task automatic iss(input logic [4:0] rd);
    bus.iss_valid = 1'b1;
    bus.iss_rd    = rd;
  endtask

  task automatic expect_wr(input string tag, input logic [4:0] a3, input logic [31:0] wd);
    check({tag, ".wr"}, {31'd0, bus.rf_wr}, 32'd1);
    check({tag, ".a3"}, {27'd0, bus.rf_a3}, {27'd0, a3});
    check({tag, ".wd"}, bus.rf_wd, wd);
  endtask

  // Decode interlock: a pipeline write never targets a pending register.
  always @(posedge clk) begin
    if (rst_n && bus.wb_valid && bus.wb_rd != 5'd0) begin
      checks++;
      assert (bus.pend_mask[bus.wb_rd] === 1'b0) else begin
        errors++;
        $error("FAIL interlock: observed pend[%0d]=%b expected=0", bus.wb_rd, bus.pend_mask[bus.wb_rd]);
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    idle();
    #3;
    check("rst.wr",    {31'd0, bus.rf_wr}, 32'd0);
    check("rst.a3",    {27'd0, bus.rf_a3}, 32'd0);
    check("rst.wd",    bus.rf_wd, 32'd0);
    check("rst.stall", {31'd0, bus.wb_stall}, 32'd0);
    check("rst.pend",  bus.pend_mask, 32'd0);
    check("rst.ready", {31'd0, bus.mdu_ready}, 32'd1);
    tick();
    tick();
    rst_n = 1'b1;

    // 1: pipeline only
    wb(5'd5, 32'h1234); tick();
    expect_wr("t1.wb5", 5'd5, 32'h1234);
    wb(5'd0, 32'hFFFF); tick();
    check("t1.rd0", {31'd0, bus.rf_wr}, 32'd0);
    idle(); tick();
    check("t1.idle", {31'd0, bus.rf_wr}, 32'd0);

    // 2: MDU on an idle port
    iss(5'd7); tick();
    check("t2.pend_set", bus.pend_mask, 32'h0000_0080);
    idle(); mdu(5'd7, 32'hCAFE); tick();
    check("t2.accept_wr", {31'd0, bus.rf_wr}, 32'd0);
    check("t2.accept_pend", bus.pend_mask, 32'h0000_0080);
    check("t2.ready", {31'd0, bus.mdu_ready}, 32'd1);
    idle(); tick();
    expect_wr("t2.mdu7", 5'd7, 32'hCAFE);
    check("t2.pend_clr", bus.pend_mask, 32'd0);
    tick();
    check("t2.after", {31'd0, bus.rf_wr}, 32'd0);

    // 3: contention, FIFO fills, stall, in-order drain
    iss(5'd10); tick();
    iss(5'd11); tick();
    check("t3.pend", bus.pend_mask, 32'h0000_0C00);
    idle(); wb(5'd1, 32'hA1); mdu(5'd10, 32'hD10); tick();
    expect_wr("t3.a1", 5'd1, 32'hA1);
    check("t3.stall0", {31'd0, bus.wb_stall}, 32'd0);
    wb(5'd1, 32'hA2); mdu(5'd11, 32'hD11); tick();
    expect_wr("t3.a2", 5'd1, 32'hA2);
    check("t3.full_ready", {31'd0, bus.mdu_ready}, 32'd0);
    check("t3.stall1", {31'd0, bus.wb_stall}, 32'd0);
    wb(5'd1, 32'hA3); mdu(5'd12, 32'hBAD); tick();
    expect_wr("t3.a3", 5'd1, 32'hA3);
    check("t3.still_full", {31'd0, bus.mdu_ready}, 32'd0);
    check("t3.stall_rise", {31'd0, bus.wb_stall}, 32'd1);
    // wb idle as the stall demands; MDU keeps offering but full refuses it
    bus.wb_valid = 1'b0; tick();
    expect_wr("t3.d10", 5'd10, 32'hD10);
    check("t3.pend10", bus.pend_mask, 32'h0000_0800);
    check("t3.stall_fall", {31'd0, bus.wb_stall}, 32'd0);
    check("t3.ready_back", {31'd0, bus.mdu_ready}, 32'd1);
    idle(); tick();
    expect_wr("t3.d11", 5'd11, 32'hD11);
    check("t3.pend11", bus.pend_mask, 32'd0);
    tick();
    check("t3.no_bad", {31'd0, bus.rf_wr}, 32'd0);

    // 4: starvation with one entry
    iss(5'd20); tick();
    idle(); wb(5'd2, 32'hB0); mdu(5'd20, 32'h5555); tick();
    expect_wr("t4.b0", 5'd2, 32'hB0);
    idle(); wb(5'd2, 32'hB1); tick();
    check("t4.stall_c1", {31'd0, bus.wb_stall}, 32'd0);
    wb(5'd2, 32'hB2); tick();
    check("t4.stall_c2", {31'd0, bus.wb_stall}, 32'd0);
    wb(5'd2, 32'hB3); tick();
    expect_wr("t4.b3", 5'd2, 32'hB3);
    check("t4.stall_c3", {31'd0, bus.wb_stall}, 32'd1);
    idle(); tick();
    expect_wr("t4.drain", 5'd20, 32'h5555);
    check("t4.stall_off", {31'd0, bus.wb_stall}, 32'd0);
    check("t4.pend", bus.pend_mask, 32'd0);

    // 5: same-cycle set and retire of x3; also x0 handling
    iss(5'd3); tick();
    idle(); mdu(5'd3, 32'h3333); tick();
    idle(); iss(5'd3); tick();
    expect_wr("t5.mdu3", 5'd3, 32'h3333);
    check("t5.set_wins", bus.pend_mask, 32'h0000_0008);
    idle(); iss(5'd0); tick();
    check("t5.iss_x0", bus.pend_mask, 32'h0000_0008);
    idle(); mdu(5'd3, 32'h4444); tick();
    idle(); tick();
    expect_wr("t5.mdu3b", 5'd3, 32'h4444);
    check("t5.pend_clr", bus.pend_mask, 32'd0);
    mdu(5'd0, 32'hABCD); tick();
    idle(); tick();
    check("t5.mdu_x0_wr", {31'd0, bus.rf_wr}, 32'd0);
    tick();
    check("t5.mdu_x0_gone", {31'd0, bus.rf_wr}, 32'd0);

    // 6: reset mid-operation
    iss(5'd8); tick();
    iss(5'd9); tick();
    idle(); wb(5'd1, 32'hC1); mdu(5'd8, 32'h88); tick();
    wb(5'd1, 32'hC2); mdu(5'd9, 32'h99); tick();
    check("t6.full", {31'd0, bus.mdu_ready}, 32'd0);
    check("t6.pend", bus.pend_mask, 32'h0000_0300);
    idle();
    rst_n = 1'b0;
    #1;
    check("t6.rst_wr",    {31'd0, bus.rf_wr}, 32'd0);
    check("t6.rst_a3",    {27'd0, bus.rf_a3}, 32'd0);
    check("t6.rst_wd",    bus.rf_wd, 32'd0);
    check("t6.rst_pend",  bus.pend_mask, 32'd0);
    check("t6.rst_stall", {31'd0, bus.wb_stall}, 32'd0);
    check("t6.rst_ready", {31'd0, bus.mdu_ready}, 32'd1);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("t6.no_stale1", {31'd0, bus.rf_wr}, 32'd0);
    tick();
    check("t6.no_stale2", {31'd0, bus.rf_wr}, 32'd0);
    check("t6.pend_after", bus.pend_mask, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
